// File: rtl/fnd_scan_dec_pkg.sv
// Shared definitions for the seven-segment scan decoder and the hex-to-segment encoder.
package fnd_scan_dec_pkg;

   localparam int unsigned SEG_W          = 7;
   localparam int unsigned NIB_W          = 4;
   localparam int unsigned NUM_DIG        = 4;
   localparam int unsigned HEX_W          = NIB_W * NUM_DIG;
   localparam int unsigned STABLE_CNT_DEF = 4;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   typedef struct packed {
      logic [HEX_W-1:0]   hex;
      logic [NUM_DIG-1:0] blank;
      logic [NUM_DIG-1:0] err;
   } fnd_out_t;

   // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble.
   function automatic logic [SEG_W-1:0] hex2seg(input logic [NIB_W-1:0] nib);
      logic [SEG_W-1:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h58;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/fnd_seg2hex.sv
// Combinational reverse lookup of an active-low segment pattern into a hex nibble.
module fnd_seg2hex
   import fnd_scan_dec_pkg::*;
(
   input  logic [SEG_W-1:0] seg_n,
   output logic [NIB_W-1:0] nibble,
   output logic             blank,
   output logic             invalid
);

   always_comb begin
      nibble  = '0;
      blank   = (seg_n == SEG_BLANK);
      invalid = ~blank;
      for (int i = 0; i < 16; i++) begin
         if (seg_n == hex2seg(NIB_W'(i))) begin
            nibble  = NIB_W'(i);
            invalid = 1'b0;
         end
      end
   end

endmodule

// File: rtl/fnd_scan_dec.sv
// Recovers four hex digits from a multiplexed active-low seven-segment display bus.
module fnd_scan_dec
   import fnd_scan_dec_pkg::*;
#(
   parameter int unsigned STABLE_CNT = STABLE_CNT_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SEG_W-1:0]   seg_n,
   input  logic [NUM_DIG-1:0] dig_n,
   input  logic               clr,
   output logic [HEX_W-1:0]   hex_val,
   output logic [NUM_DIG-1:0] dig_blank,
   output logic [NUM_DIG-1:0] dig_err,
   output logic               frame_valid
);

   localparam int unsigned   SAMP_W  = SEG_W + NUM_DIG;
   localparam int unsigned   CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(STABLE_CNT - 1);

   logic [SEG_W-1:0]   seg_s1_q, seg_s2_q;
   logic [NUM_DIG-1:0] dig_s1_q, dig_s2_q;
   logic [SAMP_W-1:0]  samp, prev_q, prev_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               active, capture;
   logic [NUM_DIG-1:0] cap_sel, seen_q, seen_d, seen_nxt;
   fnd_out_t           out_q, out_d;
   logic               fv_q, fv_d;
   logic [NIB_W-1:0]   dec_nib;
   logic               dec_blank, dec_invalid;

   // Two-flop synchronizers; idle (all ones) out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1_q <= '1;
         seg_s2_q <= '1;
         dig_s1_q <= '1;
         dig_s2_q <= '1;
      end else begin
         seg_s1_q <= seg_n;
         seg_s2_q <= seg_s1_q;
         dig_s1_q <= dig_n;
         dig_s2_q <= dig_s1_q;
      end
   end

   // Dwell counter; a capture fires once when the registered count hits STABLE_CNT-1.
   always_comb begin
      samp   = {dig_s2_q, seg_s2_q};
      prev_d = samp;
      active = $onehot(~dig_s2_q);
      cnt_d  = '0;
      if (active && (samp == prev_q)) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end
      capture = (cnt_q == CAP_CNT);
      cap_sel = ~prev_q[SEG_W +: NUM_DIG];
   end

   fnd_seg2hex u_seg2hex (
      .seg_n   (prev_q[SEG_W-1:0]),
      .nibble  (dec_nib),
      .blank   (dec_blank),
      .invalid (dec_invalid)
   );

   // Capture/clear update of the output registers and frame tracking.
   always_comb begin
      out_d    = out_q;
      seen_d   = seen_q;
      fv_d     = 1'b0;
      seen_nxt = seen_q | cap_sel;
      if (clr) begin
         out_d  = '0;
         seen_d = '0;
      end else if (capture) begin
         for (int k = 0; k < NUM_DIG; k++) begin
            if (cap_sel[k]) begin
               out_d.blank[k] = dec_blank;
               out_d.err[k]   = dec_invalid;
               if (dec_blank) begin
                  out_d.hex[NIB_W*k +: NIB_W] = '0;
               end else if (!dec_invalid) begin
                  out_d.hex[NIB_W*k +: NIB_W] = dec_nib;
               end
            end
         end
         if (&seen_nxt) begin
            fv_d   = 1'b1;
            seen_d = '0;
         end else begin
            seen_d = seen_nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= '1;
         cnt_q  <= '0;
         seen_q <= '0;
         out_q  <= '0;
         fv_q   <= 1'b0;
      end else begin
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
         seen_q <= seen_d;
         out_q  <= out_d;
         fv_q   <= fv_d;
      end
   end

   assign hex_val     = out_q.hex;
   assign dig_blank   = out_q.blank;
   assign dig_err     = out_q.err;
   assign frame_valid = fv_q;

endmodule

// File: tb/tb_fnd_scan_dec.sv
// Directed scoreboard bench for the seven-segment scan decoder.
module tb_fnd_scan_dec;
   import fnd_scan_dec_pkg::*;

   localparam int unsigned S = 4;

   logic        clk;
   logic        rst_n;
   logic [6:0]  seg_n;
   logic [3:0]  dig_n;
   logic        clr;
   logic [15:0] hex_val;
   logic [3:0]  dig_blank;
   logic [3:0]  dig_err;
   logic        frame_valid;

   fnd_out_t exp_q[$];
   int vectors     = 0;
   int miscompares = 0;
   int fv_cnt      = 0;

   fnd_scan_dec #(.STABLE_CNT(S)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_n       (seg_n),
      .dig_n       (dig_n),
      .clr         (clr),
      .hex_val     (hex_val),
      .dig_blank   (dig_blank),
      .dig_err     (dig_err),
      .frame_valid (frame_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && frame_valid) fv_cnt++;
   end

   // Drive a digit/segment pair from the current negedge and hold it n cycles.
   task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n);
      dig_n = d;
      seg_n = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_out(input logic [15:0] h, input logic [3:0] b, input logic [3:0] e);
      fnd_out_t x;
      x.hex   = h;
      x.blank = b;
      x.err   = e;
      exp_q.push_back(x);
   endtask

   task automatic check(input string tag);
      fnd_out_t e;
      e = exp_q.pop_front();
      vectors++;
      assert (hex_val === e.hex) else begin
         miscompares++;
         $error("FAIL %s hex_val observed=%h expected=%h", tag, hex_val, e.hex);
      end
      vectors++;
      assert (dig_blank === e.blank) else begin
         miscompares++;
         $error("FAIL %s dig_blank observed=%b expected=%b", tag, dig_blank, e.blank);
      end
      vectors++;
      assert (dig_err === e.err) else begin
         miscompares++;
         $error("FAIL %s dig_err observed=%b expected=%b", tag, dig_err, e.err);
      end
   endtask

   task automatic check_frames(input string tag, input int n);
      vectors++;
      assert (fv_cnt === n) else begin
         miscompares++;
         $error("FAIL %s frame_count observed=%0d expected=%0d", tag, fv_cnt, n);
      end
   endtask

   task automatic check_fv_low(input string tag);
      vectors++;
      assert (frame_valid === 1'b0) else begin
         miscompares++;
         $error("FAIL %s frame_valid observed=%b expected=0", tag, frame_valid);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      seg_n = 7'h7F;
      dig_n = 4'hF;
      clr   = 1'b0;
      repeat (3) @(negedge clk);
      expect_out(16'h0000, 4'b0000, 4'b0000);
      check("reset");
      check_fv_low("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Full frame 3,0,1,F on digits 0..3.
      drive(4'b1110, 7'h30, 8);
      drive(4'b1101, 7'h40, 8);
      drive(4'b1011, 7'h79, 8);
      drive(4'b0111, 7'h0E, 8);
      expect_out(16'hF103, 4'b0000, 4'b0000);
      check("frame1");
      check_frames("frame1", 1);
      drive(4'hF, 7'h7F, 4);
      check_frames("frame1_single", 1);

      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      expect_out(16'h0000, 4'b0000, 4'b0000);
      check("clr");

      // Short dwell must not capture, full dwell must.
      drive(4'b1110, 7'h24, 3);
      drive(4'hF, 7'h7F, 6);
      expect_out(16'h0000, 4'b0000, 4'b0000);
      check("short_dwell");
      drive(4'b1110, 7'h24, 10);
      expect_out(16'h0002, 4'b0000, 4'b0000);
      check("full_dwell");

      // Two digit selects low is idle.
      drive(4'b1100, 7'h00, 20);
      expect_out(16'h0002, 4'b0000, 4'b0000);
      check("two_low");

      drive(4'b1011, 7'h7F, 8);
      expect_out(16'h0002, 4'b0100, 4'b0000);
      check("blank2");
      drive(4'b1011, 7'h55, 8);
      expect_out(16'h0002, 4'b0000, 4'b0100);
      check("err2");

      // Recapture digit 0, then digit 1; seen is {0,1,2}.
      drive(4'b1110, 7'h19, 8);
      expect_out(16'h0004, 4'b0000, 4'b0100);
      check("recapture0");
      drive(4'b1101, 7'h12, 8);
      expect_out(16'h0054, 4'b0000, 4'b0100);
      check("digit1");
      check_frames("no_frame_yet", 1);

      // clr coincides with the capture cycle of the fourth digit.
      drive(4'b0111, 7'h02, S + 2);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      drive(4'hF, 7'h7F, 6);
      expect_out(16'h0000, 4'b0000, 4'b0000);
      check("clr_vs_capture");
      check_frames("clr_vs_capture", 1);

      drive(4'b1110, 7'h00, 8);
      drive(4'b1101, 7'h10, 8);
      drive(4'b1011, 7'h08, 8);
      drive(4'b0111, 7'h03, 8);
      expect_out(16'hBA98, 4'b0000, 4'b0000);
      check("frame2");
      check_frames("frame2", 2);

      // Reset mid-dwell on digit 1, then exact full-dwell latency.
      drive(4'b1101, 7'h21, 3);
      rst_n = 1'b0;
      #1;
      expect_out(16'h0000, 4'b0000, 4'b0000);
      check("async_reset");
      check_fv_low("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (S + 2) @(negedge clk);
      expect_out(16'h0000, 4'b0000, 4'b0000);
      check("post_reset_early");
      @(negedge clk);
      expect_out(16'h00D0, 4'b0000, 4'b0000);
      check("post_reset_capture");
      check_frames("final", 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
